// File: rtl/servo_array_slew_pkg.sv
// Shared constants and types for the servo_array_slew controller.
// Build option: define SERVO_SLEW_EN to enable per-period slew limiting.
package servo_pkg;

  localparam int unsigned ANG_MAX          = 180;
  localparam int unsigned DEF_DUTY_W       = 20;
  localparam int unsigned DEF_PERIOD_CYC   = 1_000_000;
  localparam int unsigned DEF_DUTY_MIN     = 25_000;
  localparam int unsigned DEF_DUTY_PER_DEG = 555;
  localparam int unsigned DEF_SLEW_STEP    = 2_775;

  typedef logic [DEF_DUTY_W-1:0] duty_t;

  typedef enum logic {
    HOLD,
    MOVING
  } ch_state_e;

endpackage

// File: rtl/servo_ang2duty.sv
// Angle-to-pulse-width conversion: clamp to ANG_MAX, then DUTY_MIN + ang*DUTY_PER_DEG.
module servo_ang2duty
  import servo_pkg::*;
#(
  parameter int unsigned ANG_W        = 8,
  parameter int unsigned DUTY_W       = DEF_DUTY_W,
  parameter int unsigned DUTY_MIN     = DEF_DUTY_MIN,
  parameter int unsigned DUTY_PER_DEG = DEF_DUTY_PER_DEG
) (
  input  logic [ANG_W-1:0]  ang,
  output logic [DUTY_W-1:0] duty
);

  logic [DUTY_W-1:0] ang_c;

  always_comb begin
    ang_c = (ang > ANG_W'(ANG_MAX)) ? DUTY_W'(ANG_MAX) : DUTY_W'(ang);
    duty  = DUTY_W'(DUTY_MIN) + ang_c * DUTY_W'(DUTY_PER_DEG);
  end

endmodule

// File: rtl/servo_array_slew.sv
// N-channel 50 Hz servo PWM driver with shared period counter and per-period slewing.
// Build option: SERVO_SLEW_EN (defined = bounded step per period, undefined = jump at commit).
module servo_array_slew
  import servo_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned ANG_W        = 8,
  parameter int unsigned DUTY_W       = DEF_DUTY_W,
  parameter int unsigned PERIOD_CYC   = DEF_PERIOD_CYC,
  parameter int unsigned DUTY_MIN     = DEF_DUTY_MIN,
`ifdef SERVO_SLEW_EN
  parameter int unsigned SLEW_STEP    = DEF_SLEW_STEP,
`endif
  parameter int unsigned DUTY_PER_DEG = DEF_DUTY_PER_DEG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*ANG_W-1:0] ang_flat,
  input  logic                  ang_valid,
  output logic                  ang_ready,
  output logic [N_CH-1:0]       pwm_out,
  output logic [N_CH-1:0]       at_target,
  output logic                  busy
);

  localparam logic [DUTY_W-1:0] CENTRE   = DUTY_W'(DUTY_MIN + (ANG_MAX / 2) * DUTY_PER_DEG);
  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PERIOD_CYC - 1);
`ifdef SERVO_SLEW_EN
  localparam logic [DUTY_W-1:0] STEP     = DUTY_W'(SLEW_STEP);
`endif

  logic [DUTY_W-1:0] cnt;
  logic              commit;
  logic              accept;

  logic [DUTY_W-1:0] cur      [N_CH];
  logic [DUTY_W-1:0] tgt      [N_CH];
  logic [DUTY_W-1:0] cur_d    [N_CH];
  logic [DUTY_W-1:0] ang_duty [N_CH];
  ch_state_e         state    [N_CH];
  ch_state_e         state_d  [N_CH];

  assign commit    = (cnt == CNT_LAST);
  assign ang_ready = !rst && !commit;
  assign accept    = ang_valid && ang_ready;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_conv
    servo_ang2duty #(
      .ANG_W       (ANG_W),
      .DUTY_W      (DUTY_W),
      .DUTY_MIN    (DUTY_MIN),
      .DUTY_PER_DEG(DUTY_PER_DEG)
    ) u_conv (
      .ang (ang_flat[gi*ANG_W +: ANG_W]),
      .duty(ang_duty[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst || commit) cnt <= '0;
    else               cnt <= cnt + 1'b1;
  end

  // State register: per-channel FSM plus the current/target duty it governs.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (rst) begin
        state[i] <= HOLD;
        cur[i]   <= CENTRE;
        tgt[i]   <= CENTRE;
      end else begin
        state[i] <= state_d[i];
        cur[i]   <= cur_d[i];
        if (accept) tgt[i] <= ang_duty[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      state_d[i] = state[i];
      case (state[i])
        HOLD:    if (tgt[i] != cur[i]) state_d[i] = MOVING;
        MOVING:  if (commit && cur_d[i] == tgt[i]) state_d[i] = HOLD;
        default: state_d[i] = HOLD;
      endcase
    end
  end

  // cur only changes on the commit cycle so a running pulse is never reshaped.
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      cur_d[i] = cur[i];
      if (commit && (state[i] == MOVING || tgt[i] != cur[i])) begin
`ifdef SERVO_SLEW_EN
        if (tgt[i] > cur[i] + STEP)      cur_d[i] = cur[i] + STEP;
        else if (cur[i] > tgt[i] + STEP) cur_d[i] = cur[i] - STEP;
        else                             cur_d[i] = tgt[i];
`else
        cur_d[i] = tgt[i];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out   <= '0;
      at_target <= '1;
      busy      <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        pwm_out[i]   <= (cnt < cur[i]);
        at_target[i] <= (cur[i] == tgt[i]);
      end
      busy <= ~&at_target;
    end
  end

endmodule

// File: tb/tb_servo_array_slew.sv
// Directed self-checking bench for servo_array_slew on a shortened PWM period.
module tb_servo_array_slew;

  localparam int unsigned P      = 500;
  localparam int          CEN    = 205;
`ifdef SERVO_SLEW_EN
  localparam int          NRAMP  = 18;
`else
  localparam int          NRAMP  = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ang_flat = {4{8'd90}};
  logic        ang_valid = 1'b0;
  logic        ang_ready;
  logic [3:0]  pwm_out;
  logic [3:0]  at_target;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int tcnt   = 0;
  int width [4];
  logic mid_busy;

  servo_array_slew #(
    .N_CH        (4),
    .ANG_W       (8),
    .DUTY_W      (20),
    .PERIOD_CYC  (P),
    .DUTY_MIN    (25),
`ifdef SERVO_SLEW_EN
    .SLEW_STEP   (10),
`endif
    .DUTY_PER_DEG(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ang_flat (ang_flat),
    .ang_valid(ang_valid),
    .ang_ready(ang_ready),
    .pwm_out  (pwm_out),
    .at_target(at_target),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) tcnt <= 0;
    else     tcnt <= (tcnt == P - 1) ? 0 : tcnt + 1;
  end

  task automatic wait_tcnt(input int t);
    int n = 0;
    while (tcnt != t && n < 2 * P) begin
      @(negedge clk);
      n++;
    end
    if (tcnt != t) begin
      checks++; errors++;
      $display("FAIL wait_tcnt: tcnt=%0d required=%0d", tcnt, t);
    end
  endtask

  // Counts high samples of each channel over one full period starting at cnt==0's output.
  task automatic measure();
    for (int c = 0; c < 4; c++) width[c] = 0;
    mid_busy = 1'bx;
    wait_tcnt(1);
    for (int i = 0; i < int'(P); i++) begin
      for (int c = 0; c < 4; c++) if (pwm_out[c] === 1'b1) width[c]++;
      if (i == int'(P) / 2) mid_busy = busy;
      if (i < int'(P) - 1) @(negedge clk);
    end
  endtask

  task automatic send(input logic [31:0] a, input int t);
    wait_tcnt(t);
    ang_flat  = a;
    ang_valid = 1'b1;
    @(negedge clk);
    ang_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (pwm_out !== 4'h0) begin errors++; $display("FAIL rst_pwm: got %h want 0", pwm_out); end
    checks++; if (at_target !== 4'hF) begin errors++; $display("FAIL rst_at_target: got %h want f", at_target); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (ang_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", ang_ready); end
    rst = 1'b0;
    measure();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (width[c] != CEN) begin errors++; $display("FAIL rst_width ch%0d: got %0d want %0d", c, width[c], CEN); end
    end
    checks++; if (at_target !== 4'hF) begin errors++; $display("FAIL idle_at_target: got %h want f", at_target); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    checks++; if (ang_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", ang_ready); end
  endtask

  task automatic test_jump();
    send({8'd90, 8'd90, 8'd90, 8'd92}, 10);
    repeat (2) @(negedge clk);
    checks++; if (at_target !== 4'b1110) begin errors++; $display("FAIL jump_pending_at_target: got %b want 1110", at_target); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL jump_pending_busy: got %b want 1", busy); end
    measure();
    checks++; if (width[0] != 209) begin errors++; $display("FAIL jump_width ch0: got %0d want 209", width[0]); end
    checks++; if (width[1] != CEN) begin errors++; $display("FAIL jump_width ch1: got %0d want %0d", width[1], CEN); end
    checks++; if (mid_busy !== 1'b0) begin errors++; $display("FAIL jump_mid_busy: got %b want 0", mid_busy); end
    repeat (2) @(negedge clk);
    checks++; if (at_target !== 4'hF) begin errors++; $display("FAIL jump_at_target: got %h want f", at_target); end
  endtask

  task automatic test_ramp();
    int exp;
    send({8'd90, 8'd90, 8'd0, 8'd92}, 10);
    for (int k = 1; k <= NRAMP; k++) begin
      measure();
      exp = (NRAMP == 1) ? 25 : CEN - 10 * k;
      checks++;
      if (width[1] != exp) begin errors++; $display("FAIL ramp_width p%0d: got %0d want %0d", k, width[1], exp); end
      checks++;
      if (mid_busy !== logic'(k < NRAMP)) begin errors++; $display("FAIL ramp_busy p%0d: got %b want %b", k, mid_busy, k < NRAMP); end
    end
    checks++; if (width[0] != 209) begin errors++; $display("FAIL ramp_other ch0: got %0d want 209", width[0]); end
  endtask

  task automatic test_clamp();
    int exp;
    send({8'd90, 8'd255, 8'd0, 8'd92}, 10);
    for (int k = 1; k <= NRAMP; k++) begin
      measure();
      exp = (NRAMP == 1) ? 385 : CEN + 10 * k;
      checks++;
      if (width[2] != exp || width[2] > 385) begin errors++; $display("FAIL clamp_width p%0d: got %0d want %0d", k, width[2], exp); end
    end
    measure();
    checks++; if (width[2] != 385) begin errors++; $display("FAIL clamp_hold: got %0d want 385", width[2]); end
    checks++; if (mid_busy !== 1'b0) begin errors++; $display("FAIL clamp_busy: got %b want 0", mid_busy); end
  endtask

  task automatic test_handshake();
    wait_tcnt(P - 1);
    ang_flat  = {8'd0, 8'd255, 8'd0, 8'd92};
    ang_valid = 1'b1;
    checks++; if (ang_ready !== 1'b0) begin errors++; $display("FAIL hs_ready_commit: got %b want 0", ang_ready); end
    @(negedge clk);
    checks++; if (ang_ready !== 1'b1) begin errors++; $display("FAIL hs_ready_cnt0: got %b want 1", ang_ready); end
    @(negedge clk);
    ang_valid = 1'b0;
    measure();
    checks++; if (width[3] != CEN) begin errors++; $display("FAIL hs_cur_period: got %0d want %0d", width[3], CEN); end
    checks++; if (mid_busy !== 1'b1) begin errors++; $display("FAIL hs_busy: got %b want 1", mid_busy); end
    measure();
    exp_hs: begin
      int exp = (NRAMP == 1) ? 25 : CEN - 10;
      checks++; if (width[3] != exp) begin errors++; $display("FAIL hs_next_period: got %0d want %0d", width[3], exp); end
    end
  endtask

  task automatic test_reset_mid();
    send({8'd90, 8'd90, 8'd180, 8'd92}, 10);
    measure();
    wait_tcnt(100);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (pwm_out !== 4'h0) begin errors++; $display("FAIL mid_rst_pwm: got %h want 0", pwm_out); end
    checks++; if (ang_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b want 0", ang_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    rst = 1'b0;
    measure();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (width[c] != CEN) begin errors++; $display("FAIL mid_rst_width ch%0d: got %0d want %0d", c, width[c], CEN); end
    end
    checks++; if (mid_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_after_busy: got %b want 0", mid_busy); end
    checks++; if (at_target !== 4'hF) begin errors++; $display("FAIL mid_rst_at_target: got %h want f", at_target); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_jump();
    test_ramp();
    test_clamp();
    test_handshake();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
